// File: rtl/sha256_digest_tx_if.sv
// Digest-in / byte-stream-out bundle for sha256_digest_tx.
// master = digest source and stream sink, slave = the serializer.
interface sha256_digest_tx_if;
    logic [255:0] hash_in;
    logic         hash_valid;
    logic         hex_mode;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_last;
    logic         busy;
    logic         overrun;

    modport master (
        output hash_in, hash_valid, hex_mode, tx_ready,
        input  tx_data, tx_valid, tx_last, busy, overrun
    );

    modport slave (
        input  hash_in, hash_valid, hex_mode, tx_ready,
        output tx_data, tx_valid, tx_last, busy, overrun
    );
endinterface

// File: rtl/sha256_digest_tx.sv
// Serializes a 256-bit digest as 32 raw bytes or 64 ASCII hex characters
// over a valid/ready byte stream, big-endian, H0 first.
module sha256_digest_tx #(
    parameter bit LOWERCASE = 1'b1
) (
    input logic              clk,
    input logic              reset,
    sha256_digest_tx_if.slave b
);
    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [7:0] ALPHA = LOWERCASE ? 8'h57 : 8'h37;

    state_e       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [255:0] dig_q, dig_d;
    logic         hex_q, hex_d;
    logic         ovr_q, ovr_d;

    logic         valid, last, fire, load;
    logic [5:0]   term;
    logic [7:0]   bin_byte, hex_byte;
    logic [3:0]   nib;

    assign valid = (state_q == SEND);
    assign term  = hex_q ? 6'd63 : 6'd31;
    assign last  = valid && (cnt_q == term);
    assign fire  = valid && b.tx_ready;

    // ~cnt selects from the MSB end, giving big-endian order
    assign bin_byte = dig_q[{~cnt_q[4:0], 3'b000} +: 8];
    assign nib      = dig_q[{~cnt_q, 2'b00} +: 4];
    assign hex_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib}
                                    : ALPHA + {4'h0, nib};

    assign b.tx_valid = valid;
    assign b.tx_last  = last;
    assign b.tx_data  = valid ? (hex_q ? hex_byte : bin_byte) : 8'h00;
    assign b.busy     = valid;
    assign b.overrun  = ovr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        hex_d   = hex_q;
        ovr_d   = ovr_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (b.hash_valid) load = 1'b1;
            end
            SEND: begin
                if (fire) begin
                    if (last) begin
                        if (b.hash_valid) load = 1'b1;
                        else state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                // only the final transfer may accept a back-to-back digest
                if (b.hash_valid && !(fire && last)) ovr_d = 1'b1;
            end
        endcase
        if (load) begin
            state_d = SEND;
            cnt_d   = 6'd0;
            dig_d   = b.hash_in;
            hex_d   = b.hex_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            dig_q   <= '0;
            hex_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            hex_q   <= hex_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_sha256_digest_tx.sv
// Scoreboard bench for sha256_digest_tx: expected units queued at capture,
// popped by a negedge monitor on each accepted transfer.
module tb_sha256_digest_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;

    sha256_digest_tx_if m ();
    sha256_digest_tx_if u ();

    sha256_digest_tx #(.LOWERCASE(1'b1)) dut (
        .clk(clk), .reset(reset), .b(m.slave)
    );
    sha256_digest_tx #(.LOWERCASE(1'b0)) dut_uc (
        .clk(clk), .reset(reset), .b(u.slave)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    int tests = 0;
    int fails = 0;
    logic [8:0] exq[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] asc(logic [3:0] n);
        string s;
        s = "0123456789abcdef";
        return s[n];
    endfunction

    task automatic push_units(logic [255:0] h, bit hx);
        if (!hx) begin
            for (int k = 0; k < 32; k++)
                exq.push_back({k == 31, h[255-8*k -: 8]});
        end else begin
            for (int c = 0; c < 64; c++)
                exq.push_back({c == 63, asc(h[255-4*c -: 4])});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(logic [255:0] h, bit hx);
        m.hash_in    = h;
        m.hex_mode   = hx;
        m.hash_valid = 1'b1;
        push_units(h, hx);
        step();
        m.hash_valid = 1'b0;
    endtask

    task automatic drain(int maxc, bit rnd);
        int n = 0;
        while ((exq.size() != 0 || m.busy) && n < maxc) begin
            if (rnd) m.tx_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m.tx_ready = 1'b1;
        chk("drain_done", (exq.size() == 0) && !m.busy, 1);
    endtask

    // monitor: transfers against scoreboard, and stability across stalls
    bit         stalled = 1'b0;
    logic [9:0] held;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {m.tx_valid, m.tx_last, m.tx_data}, held);
            if (m.tx_valid && m.tx_ready) begin
                if (exq.size() == 0) chk("unexpected_unit", m.tx_valid, 0);
                else chk("unit", {m.tx_last, m.tx_data}, exq.pop_front());
            end
            stalled = m.tx_valid && !m.tx_ready;
            held    = {m.tx_valid, m.tx_last, m.tx_data};
        end
    end

    initial begin
        m.hash_in = D_TWO; m.hex_mode = 1'b0;
        m.hash_valid = 1'b1; m.tx_ready = 1'b1;
        u.hash_in = D_EMPTY; u.hex_mode = 1'b1;
        u.hash_valid = 1'b0; u.tx_ready = 1'b1;

        // reset with hash_valid held high: must be ignored
        step(); step();
        reset = 1'b0;
        m.hash_valid = 1'b0;
        chk("rst_valid", m.tx_valid, 0);
        chk("rst_last", m.tx_last, 0);
        chk("rst_data", m.tx_data, 0);
        chk("rst_busy", m.busy, 0);
        chk("rst_ovr", m.overrun, 0);
        step();
        chk("rst_idle", m.busy, 0);

        // binary, continuous ready: 32 consecutive cycles
        capture(D_ABC, 1'b0);
        chk("bin_latency", m.tx_valid, 1);
        for (int i = 0; i < 31; i++) step();
        chk("bin_last_on_31", m.tx_last, 1);
        step();
        chk("bin_busy_after", m.busy, 0);
        chk("bin_q_empty", exq.size(), 0);

        // hex, lowercase
        capture(D_EMPTY, 1'b1);
        chk("hex_first", m.tx_data, 8'h65);
        for (int i = 0; i < 63; i++) step();
        chk("hex_last_on_63", m.tx_last, 1);
        step();
        chk("hex_busy_after", m.busy, 0);

        // hex, uppercase instance
        u.hash_valid = 1'b1;
        step();
        u.hash_valid = 1'b0;
        chk("uc_first", u.tx_data, 8'h45);
        step();
        chk("uc_second", u.tx_data, 8'h33);
        for (int i = 0; i < 63; i++) step();
        chk("uc_done", u.busy, 0);

        // random backpressure
        m.tx_ready = 1'($urandom_range(0, 1));
        capture(D_ABC, 1'b0);
        drain(600, 1'b1);

        // overrun at unit 10, then back-to-back digest
        capture(D_ABC, 1'b0);
        for (int i = 0; i < 10; i++) step();
        m.hash_in = D_TWO; m.hash_valid = 1'b1;
        step();
        m.hash_valid = 1'b0;
        chk("ovr_set", m.overrun, 1);
        for (int i = 0; i < 20; i++) step();
        chk("b2b_last", m.tx_last, 1);
        capture(D_TWO, 1'b0);
        chk("b2b_valid", m.tx_valid, 1);
        chk("b2b_ovr_same", m.overrun, 1);
        drain(40, 1'b0);

        // reset mid-stream at unit 20
        capture(D_ABC, 1'b0);
        for (int i = 0; i < 20; i++) step();
        reset = 1'b1;
        step();
        exq.delete();
        chk("mid_rst_valid", m.tx_valid, 0);
        chk("mid_rst_ovr", m.overrun, 0);
        reset = 1'b0;
        step(); step();
        chk("post_rst_idle", m.tx_valid, 0);
        capture(D_TWO, 1'b0);
        chk("post_rst_first", m.tx_data, D_TWO[255:248]);
        drain(40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
